// File: rtl/io_out_fifo.sv
// Output-side FIFO between the processor I/O write port and an external consumer.
// Writes cannot stall, so a write into a full FIFO is dropped and latches a sticky overflow flag.
module io_out_fifo #(
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 8,
    localparam int NBADDR = $clog2(NUIOOU),
    localparam int PW     = $clog2(FDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NBADDR-1:0] addr_out,
    input  logic              out_en,
    output logic [NUBITS-1:0] m_data,
    output logic [NBADDR-1:0] m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);

    logic [NBADDR+NUBITS-1:0] mem [FDEPTH];
    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic                     pop;
    logic                     push;
    logic                     drop;

    assign m_valid = (count != '0);
    assign full    = (count == DEPTH_C);
    assign pop     = m_valid & m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = out_en & (~full | pop);
    assign drop    = out_en & full & ~pop;

    // First-word-fall-through head, forced to zero when nothing is stored.
    always_comb begin
        m_data = '0;
        m_addr = '0;
        if (m_valid) begin
            m_data = mem[rd_ptr][NUBITS-1:0];
            m_addr = mem[rd_ptr][NBADDR+NUBITS-1:NUBITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= {addr_out, io_out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Setting wins over clearing when both happen in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
